// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and data access,
// one transaction in flight, data side wins ties. Optional wait-state timeout: ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_flush_if,
  output logic                o_if_valid,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_stall_if,
  input  logic                i_dm_req,
  input  logic                i_dm_we,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  input  logic [DATA_W/8-1:0] i_dm_be,
  output logic                o_dm_valid,
  output logic [DATA_W-1:0]   o_dm_rdata,
  output logic                o_stall_dm,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_be,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_bus_err
);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_DM} state_t;

  state_t            state, state_nxt;
  logic              discard, discard_nxt;
  logic              timeout_hit;
  logic              rsp_take;
  logic [DATA_W-1:0] rsp_data;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = (state != IDLE) && !i_mem_rvalid && (wait_cnt == CNT_W'(TIMEOUT));

  // Counter sits at zero in IDLE so every WAIT_x starts from a clean count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               wait_cnt <= '0;
    else if (state == IDLE)  wait_cnt <= '0;
    else if (!rsp_take)      wait_cnt <= wait_cnt + CNT_W'(1);
  end
`else
  if (TIMEOUT < 1) begin : g_timeout_range
    $error("TIMEOUT must be at least 1");
  end
  assign timeout_hit = 1'b0;
`endif

  // A timeout ends the transaction like a response, but with zero data.
  assign rsp_take = (state != IDLE) && (i_mem_rvalid || timeout_hit);
  assign rsp_data = i_mem_rvalid ? i_mem_rdata : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = '0;
    o_if_valid  = 1'b0;
    o_if_rdata  = '0;
    o_dm_valid  = 1'b0;
    o_dm_rdata  = '0;
    if (!i_rst) begin
      case (state)
        IDLE: begin
          o_mem_req = i_dm_req | i_if_req;
          if (i_dm_req) begin
            o_mem_we    = i_dm_we;
            o_mem_addr  = i_dm_addr;
            o_mem_wdata = i_dm_wdata;
            o_mem_be    = i_dm_be;
          end else if (i_if_req) begin
            o_mem_addr  = i_if_addr;
            o_mem_be    = '1;
          end
          if (o_mem_req && i_mem_gnt) begin
            state_nxt   = i_dm_req ? WAIT_DM : WAIT_IF;
            discard_nxt = !i_dm_req && i_flush_if;
          end
        end
        WAIT_IF: begin
          if (rsp_take) begin
            o_if_valid  = !discard;
            o_if_rdata  = discard ? '0 : rsp_data;
            discard_nxt = 1'b0;
            state_nxt   = IDLE;
          end else if (i_flush_if) begin
            discard_nxt = 1'b1;
          end
        end
        WAIT_DM: begin
          if (rsp_take) begin
            o_dm_valid = 1'b1;
            o_dm_rdata = rsp_data;
            state_nxt  = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign o_bus_err  = timeout_hit & ~i_rst;
  assign o_stall_if = i_if_req & ~o_if_valid;
  assign o_stall_dm = i_dm_req & ~o_dm_valid;

endmodule
